// File: rtl/sound_sequencer_if.sv
// DMA read port and buzzer command port of the sound sequencer.
// master = sequencer side, slave = memory/buzzer side.
interface sound_sequencer_if;
  logic        startDMA;
  logic [15:0] addrDMA;
  logic [15:0] fromMemDMA;
  logic        rdyDMA;
  logic [23:0] cmd;
  logic        cmdStart;

  modport master (
    output startDMA, addrDMA, cmd, cmdStart,
    input  fromMemDMA, rdyDMA
  );

  modport slave (
    input  startDMA, addrDMA, cmd, cmdStart,
    output fromMemDMA, rdyDMA
  );
endinterface

// File: rtl/sound_sequencer.sv
// Sound sequencer: fetches two-word events over DMA, issues buzzer commands, waits delay ticks.
// Optional macro SOUND_SEQUENCER_LOOP_EN: END_OP with payload[0]=1 restarts at the base latched on go.
module sound_sequencer #(
  parameter int unsigned TICK_DIV = 50000,
  parameter logic [7:0]  END_OP   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  stop,
  input  logic [15:0]           baseAddr,
  output logic                  busy,
  sound_sequencer_if.master     dma
);

  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, ISSUE, WAIT} state_e;

  localparam logic [23:0] TICK24 = TICK_DIV[23:0];

  state_e      state_q;
  logic [15:0] ptr_q;
  logic [7:0]  delay_q;
  logic [7:0]  op_q;
  logic [23:0] cnt_q;
  logic        start_q;
  logic [15:0] addr_q;
  logic [23:0] cmd_q;
  logic        cmd_start_q;
  logic        pend_q;
  logic [1:0]  drop_q, drop_d;
  logic        rdy_fresh;
  logic        kill;
  logic [23:0] wait_len;
`ifdef SOUND_SEQUENCER_LOOP_EN
  logic [15:0] base_q;
  logic        loop_q;
`endif

  assign busy         = (state_q != IDLE);
  assign dma.startDMA = start_q;
  assign dma.addrDMA  = addr_q;
  assign dma.cmd      = cmd_q;
  assign dma.cmdStart = cmd_start_q;

  // Completions of fetches abandoned by stop/restart are counted and swallowed
  // so a late rdyDMA is never mistaken for data of a newer fetch.
  assign rdy_fresh = dma.rdyDMA && (drop_q == 2'd0);
  assign kill      = stop || go;
  assign wait_len  = {16'd0, delay_q} * TICK24;

  always_comb begin
    drop_d = drop_q;
    if (dma.rdyDMA && (drop_q != 2'd0))
      drop_d = drop_q - 2'd1;
    if (kill && pend_q && !rdy_fresh && (drop_d != 2'd3))
      drop_d = drop_d + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      delay_q     <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      addr_q      <= '0;
      cmd_q       <= '0;
      cmd_start_q <= 1'b0;
      pend_q      <= 1'b0;
      drop_q      <= '0;
`ifdef SOUND_SEQUENCER_LOOP_EN
      base_q      <= '0;
      loop_q      <= 1'b0;
`endif
    end else begin
      start_q     <= 1'b0;
      cmd_start_q <= 1'b0;
      drop_q      <= drop_d;
      if (stop) begin
        state_q <= IDLE;
        pend_q  <= 1'b0;
      end else if (go) begin
        state_q <= FETCH0;
        ptr_q   <= baseAddr;
        addr_q  <= baseAddr;
        start_q <= 1'b1;
        pend_q  <= 1'b1;
`ifdef SOUND_SEQUENCER_LOOP_EN
        base_q  <= baseAddr;
`endif
      end else begin
        case (state_q)
          IDLE: ;
          FETCH0: if (rdy_fresh) begin
            delay_q <= dma.fromMemDMA[15:8];
            op_q    <= dma.fromMemDMA[7:0];
            ptr_q   <= ptr_q + 16'd1;
            addr_q  <= ptr_q + 16'd1;
            start_q <= 1'b1;
            state_q <= FETCH1;
          end
          FETCH1: if (rdy_fresh) begin
            ptr_q   <= ptr_q + 16'd1;
            pend_q  <= 1'b0;
            state_q <= ISSUE;
`ifdef SOUND_SEQUENCER_LOOP_EN
            loop_q  <= dma.fromMemDMA[0];
`endif
            if (op_q != END_OP) begin
              cmd_start_q <= 1'b1;
              cmd_q       <= {op_q, dma.fromMemDMA};
            end
          end
          ISSUE: begin
            if (op_q != END_OP) begin
              if (delay_q != 8'd0) begin
                state_q <= WAIT;
                cnt_q   <= '0;
              end else begin
                state_q <= FETCH0;
                addr_q  <= ptr_q;
                start_q <= 1'b1;
                pend_q  <= 1'b1;
              end
            end else begin
`ifdef SOUND_SEQUENCER_LOOP_EN
              if (loop_q) begin
                state_q <= FETCH0;
                ptr_q   <= base_q;
                addr_q  <= base_q;
                start_q <= 1'b1;
                pend_q  <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
`else
              state_q <= IDLE;
`endif
            end
          end
          WAIT: begin
            if (cnt_q == wait_len - 24'd1) begin
              state_q <= FETCH0;
              addr_q  <= ptr_q;
              start_q <= 1'b1;
              pend_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 24'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer: DMA memory responder plus a command scoreboard.
module tb_sound_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] baseAddr = '0;
  logic        busy;

  sound_sequencer_if bus();

  sound_sequencer #(.TICK_DIV(4), .END_OP(8'hFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .stop     (stop),
    .baseAddr (baseAddr),
    .busy     (busy),
    .dma      (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 2;
  int cmd_cnt = 0;
  int last_rdy_cyc = 0;
  int last_cmd_cyc = 0;
  logic [15:0] mem [0:65535];
  logic [23:0] exp_q [$];
  logic [15:0] st_addr [$];
  int          st_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: answers each startDMA lat cycles later (lat >= 2).
  initial begin
    int rcnt;
    logic [15:0] raddr;
    rcnt = 0;
    raddr = '0;
    bus.rdyDMA = 1'b0;
    bus.fromMemDMA = '0;
    forever begin
      @(negedge clk);
      bus.rdyDMA = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          bus.rdyDMA = 1'b1;
          bus.fromMemDMA = mem[raddr];
          last_rdy_cyc = cyc;
        end
      end
      if (bus.startDMA) begin
        raddr = bus.addrDMA;
        rcnt = lat - 1;
      end
    end
  end

  // Output monitor: scoreboard pop on every cmdStart, startDMA log.
  initial forever begin
    @(negedge clk);
    if (bus.startDMA) begin
      st_addr.push_back(bus.addrDMA);
      st_cyc.push_back(cyc);
    end
    if (bus.cmdStart) begin
      cmd_cnt++;
      last_cmd_cyc = cyc;
      chk("excl_start", {31'd0, bus.startDMA}, 32'd0);
      chk("cmd_latency", cyc, last_rdy_cyc + 1);
      if (exp_q.size() == 0) chk("unexpected_cmd", {8'd0, bus.cmd}, 32'hFFFFFFFF);
      else chk("cmd", {8'd0, bus.cmd}, {8'd0, exp_q.pop_front()});
    end
  end

  task automatic pulse_go(input logic [15:0] a);
    @(negedge clk);
    baseAddr = a;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_cmds(input string tag, input int target, input int budget);
    int n = 0;
    while (cmd_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (cmd_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c0, n;
    mem[16'h0100] = 16'h0001; mem[16'h0101] = 16'h0125;
    mem[16'h0102] = 16'h00FF; mem[16'h0103] = 16'h0000;
    mem[16'h0300] = 16'h0301; mem[16'h0301] = 16'h1234;
    mem[16'h0302] = 16'h00FF; mem[16'h0303] = 16'h0000;
    mem[16'h0400] = 16'h0002; mem[16'h0401] = 16'h5555;
    mem[16'hFFFF] = 16'h0007; mem[16'h0000] = 16'hABCD;
    mem[16'h0001] = 16'h00FF; mem[16'h0002] = 16'h0000;
    mem[16'h0500] = 16'h0009; mem[16'h0501] = 16'h4242;
    mem[16'h0502] = 16'h00FF; mem[16'h0503] = 16'h0001;
    mem[16'h0200] = 16'h0004; mem[16'h0201] = 16'h7777;
    mem[16'h0202] = 16'h00FF; mem[16'h0203] = 16'h0000;

    // reset overrides a concurrent go
    settle(2);
    go = 1'b1;
    baseAddr = 16'h0100;
    settle(2);
    go = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, bus.startDMA}, 32'd0);
    chk("rst_addr", {16'd0, bus.addrDMA}, 32'd0);
    chk("rst_cmd", {8'd0, bus.cmd}, 32'd0);
    chk("rst_cmdstart", {31'd0, bus.cmdStart}, 32'd0);
    rst = 1'b0;
    settle(2);

    // single event, delay 0
    st_addr.delete(); st_cyc.delete();
    exp_q.push_back(24'h010125);
    pulse_go(16'h0100);
    wait_idle("single_idle", 100);
    chk("single_cnt", cmd_cnt, 1);
    chk("single_nstart", st_addr.size(), 4);
    chk("single_a0", {16'd0, st_addr[0]}, 32'h0100);
    chk("single_a3", {16'd0, st_addr[3]}, 32'h0103);
    chk("single_nodelay", st_cyc[2] - last_cmd_cyc, 1);

    // delay 3 ticks x 4 clocks
    st_addr.delete(); st_cyc.delete();
    exp_q.push_back(24'h011234);
    pulse_go(16'h0300);
    wait_idle("delay_idle", 200);
    chk("delay_cycles", st_cyc[2] - (last_cmd_cyc + 1), 12);
    chk("delay_addr", {16'd0, st_addr[2]}, 32'h0302);

    // abort in FETCH1, late completion afterwards
    lat = 5;
    c0 = cmd_cnt;
    st_addr.delete(); st_cyc.delete();
    pulse_go(16'h0400);
    n = 0;
    while (!(bus.startDMA && bus.addrDMA == 16'h0401) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_f1", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    pulse_stop();
    chk("abort_idle", {31'd0, busy}, 32'd0);
    settle(10);
    chk("abort_nocmd", cmd_cnt, c0);
    chk("abort_nstart", st_addr.size(), 2);
    lat = 2;
    exp_q.push_back(24'h010125);
    pulse_go(16'h0100);
    wait_idle("after_abort_idle", 100);
    chk("after_abort_cnt", cmd_cnt, c0 + 1);

    // pointer wrap
    st_addr.delete(); st_cyc.delete();
    exp_q.push_back(24'h07ABCD);
    pulse_go(16'hFFFF);
    wait_idle("wrap_idle", 100);
    chk("wrap_w0", {16'd0, st_addr[0]}, 32'hFFFF);
    chk("wrap_w1", {16'd0, st_addr[1]}, 32'h0000);
    chk("wrap_next", {16'd0, st_addr[2]}, 32'h0001);

    // END_OP with payload[0]=1
    c0 = cmd_cnt;
    st_addr.delete(); st_cyc.delete();
`ifdef SOUND_SEQUENCER_LOOP_EN
    exp_q.push_back(24'h094242);
    exp_q.push_back(24'h094242);
    pulse_go(16'h0500);
    wait_cmds("loop_cmds", c0 + 2, 200);
    pulse_stop();
    chk("loop_stopped", {31'd0, busy}, 32'd0);
    chk("loop_restart_addr", {16'd0, st_addr[4]}, 32'h0500);
    settle(10);
`else
    exp_q.push_back(24'h094242);
    pulse_go(16'h0500);
    wait_idle("noloop_idle", 100);
    chk("noloop_cnt", cmd_cnt, c0 + 1);
    chk("noloop_nstart", st_addr.size(), 4);
`endif

    // go and stop together from IDLE
    st_addr.delete(); st_cyc.delete();
    @(negedge clk);
    baseAddr = 16'h0100;
    go = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    go = 1'b0;
    stop = 1'b0;
    chk("conflict_busy", {31'd0, busy}, 32'd0);
    settle(3);
    chk("conflict_nstart", st_addr.size(), 0);

    // restart during WAIT
    c0 = cmd_cnt;
    exp_q.push_back(24'h011234);
    pulse_go(16'h0300);
    wait_cmds("rewait_cmd", c0 + 1, 100);
    settle(2);
    st_addr.delete(); st_cyc.delete();
    exp_q.push_back(24'h047777);
    pulse_go(16'h0200);
    chk("restart_addr", {16'd0, st_addr[0]}, 32'h0200);
    wait_idle("restart_idle", 100);
    chk("restart_cnt", cmd_cnt, c0 + 2);

    settle(5);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
